// File: rtl/sw_input_ctrl_pkg.sv
// rtl/sw_input_ctrl_pkg.sv - shared register indices and widths for the switch-input peripheral
package sw_input_ctrl_pkg;

    localparam int BUS_DW               = 32;
    localparam int DEFAULT_DEBOUNCE_CYC = 50000;

    localparam logic [1:0] SW_REG_DATA  = 2'd0;
    localparam logic [1:0] SW_REG_EDGE  = 2'd1;
    localparam logic [1:0] SW_REG_IRQEN = 2'd2;

endpackage

// File: rtl/sw_debounce_bit.sv
// rtl/sw_debounce_bit.sv - two-flop synchronizer and debounce counter for one switch input
module sw_debounce_bit #(
    parameter int DEBOUNCE_CYC = 50000,
    parameter int CNT_W        = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic chg
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic             sync0;
    logic             sync1;
    logic [CNT_W-1:0] cnt;

    // chg is combinational so the top's edge flag sets on the same edge q updates
    assign chg = (sync1 != q) && (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync0 <= 1'b0;
            sync1 <= 1'b0;
            q     <= 1'b0;
            cnt   <= '0;
        end else begin
            sync0 <= d;
            sync1 <= sync0;
            if (sync1 == q) begin
                cnt <= '0;
            end else if (chg) begin
                q   <= sync1;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sw_input_ctrl.sv
// rtl/sw_input_ctrl.sv - debounced switch bank with sticky edge flags and irq; SW_IRQ_EN enables the IRQ_EN mask
module sw_input_ctrl
    import sw_input_ctrl_pkg::*;
#(
    parameter int N_SW         = 8,
    parameter int DEBOUNCE_CYC = DEFAULT_DEBOUNCE_CYC,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_SW-1:0]   sw_in,
    input  logic              bus_req,
    input  logic              bus_we,
    input  logic [3:0]        bus_addr,
    input  logic [BUS_DW-1:0] bus_wdata,
    output logic [BUS_DW-1:0] bus_rdata,
    output logic              bus_ack,
    output logic              irq
);

    logic [N_SW-1:0]   stable;
    logic [N_SW-1:0]   chg;
    logic [N_SW-1:0]   edge_flags;
    logic [N_SW-1:0]   irq_en;
    logic [N_SW-1:0]   w1c;
    logic [BUS_DW-1:0] rd_mux;
    logic [1:0]        reg_sel;
    logic              wr_strobe;
    logic              unused_bits;

    assign reg_sel     = bus_addr[3:2];
    assign wr_strobe   = bus_req && bus_we;
    assign unused_bits = ^{bus_addr[1:0], bus_wdata[BUS_DW-1:N_SW]};

    for (genvar i = 0; i < N_SW; i++) begin : g_bit
        sw_debounce_bit #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC),
            .CNT_W        (CNT_W)
        ) u_db (
            .clk (clk),
            .rst (rst),
            .d   (sw_in[i]),
            .q   (stable[i]),
            .chg (chg[i])
        );
    end

    always_comb begin
        w1c    = '0;
        rd_mux = '0;
        if (wr_strobe && (reg_sel == SW_REG_EDGE)) begin
            w1c = bus_wdata[N_SW-1:0];
        end
        case (reg_sel)
            SW_REG_DATA:  rd_mux = BUS_DW'(stable);
            SW_REG_EDGE:  rd_mux = BUS_DW'(edge_flags);
            SW_REG_IRQEN: rd_mux = BUS_DW'(irq_en);
            default:      rd_mux = '0;
        endcase
    end

    // a new edge overrides a same-cycle clear so no change is ever lost
    always_ff @(posedge clk) begin
        if (rst) begin
            edge_flags <= '0;
            bus_ack    <= 1'b0;
            bus_rdata  <= '0;
        end else begin
            edge_flags <= (edge_flags & ~w1c) | chg;
            bus_ack    <= bus_req;
            bus_rdata  <= (bus_req && !bus_we) ? rd_mux : '0;
        end
    end

`ifdef SW_IRQ_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_en <= '0;
            irq    <= 1'b0;
        end else begin
            if (wr_strobe && (reg_sel == SW_REG_IRQEN)) begin
                irq_en <= bus_wdata[N_SW-1:0];
            end
            irq <= |(edge_flags & irq_en);
        end
    end
`else
    assign irq_en = '0;
    assign irq    = 1'b0;
`endif

endmodule

// File: tb/tb_sw_input_ctrl.sv
// tb/tb_sw_input_ctrl.sv - self-checking bench for sw_input_ctrl with a sliding-window reference model
module tb_sw_input_ctrl;

    localparam int D = 4;

`ifdef SW_IRQ_EN
    localparam logic [31:0] IRQEN_RB = 32'h0000_00A5;
`else
    localparam logic [31:0] IRQEN_RB = 32'h0000_0000;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  sw_in = 8'h00;
    logic        bus_req = 1'b0;
    logic        bus_we = 1'b0;
    logic [3:0]  bus_addr = 4'h0;
    logic [31:0] bus_wdata = 32'h0;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        irq;

    int n_chk  = 0;
    int n_fail = 0;

    sw_input_ctrl #(
        .N_SW         (8),
        .DEBOUNCE_CYC (D),
        .CNT_W        (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sw_in     (sw_in),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ack   (bus_ack),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 30)
                $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a bit is accepted once its last D synchronized samples all disagree with stable
    logic [7:0]  hist [0:D+1];
    logic [7:0]  m_stable, m_edge, m_irqen, chg_m, w_and, w_or, w1c_m;
    logic        m_ack, m_irq;
    logic        m_valid = 1'b0;
    logic [31:0] m_rdata, rd_m;

    task automatic model_step();
        m_valid = 1'b1;
        if (rst) begin
            for (int k = 0; k <= D + 1; k++) hist[k] = 8'h00;
            m_stable = 8'h00; m_edge = 8'h00; m_irqen = 8'h00;
            m_irq = 1'b0; m_ack = 1'b0; m_rdata = 32'h0;
        end else begin
            case (bus_addr[3:2])
                2'd0:    rd_m = {24'h0, m_stable};
                2'd1:    rd_m = {24'h0, m_edge};
                2'd2:    rd_m = {24'h0, m_irqen};
                default: rd_m = 32'h0;
            endcase
            m_ack   = bus_req;
            m_rdata = (bus_req && !bus_we) ? rd_m : 32'h0;
`ifdef SW_IRQ_EN
            m_irq = |(m_edge & m_irqen);
`else
            m_irq = 1'b0;
`endif
            for (int k = D + 1; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = sw_in;
            w_and = 8'hFF;
            w_or  = 8'h00;
            for (int k = 2; k <= D + 1; k++) begin
                w_and = w_and & hist[k];
                w_or  = w_or | hist[k];
            end
            chg_m = (w_and & ~m_stable) | (~w_or & m_stable);
            w1c_m = (bus_req && bus_we && bus_addr[3:2] == 2'd1) ? bus_wdata[7:0] : 8'h00;
            m_edge   = (m_edge & ~w1c_m) | chg_m;
            m_stable = m_stable ^ chg_m;
`ifdef SW_IRQ_EN
            if (bus_req && bus_we && bus_addr[3:2] == 2'd2) m_irqen = bus_wdata[7:0];
`endif
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (m_valid) begin
            check("ack_model", {31'h0, bus_ack}, {31'h0, m_ack});
            check("irq_model", {31'h0, irq}, {31'h0, m_irq});
            if (m_ack) check("rdata_model", bus_rdata, m_rdata);
        end
    end

    task automatic bus_rd(input logic [3:0] a, output logic [31:0] d);
        bus_req = 1'b1; bus_we = 1'b0; bus_addr = a;
        @(negedge clk);
        bus_req = 1'b0;
        d = bus_rdata;
        check("ack_rd", {31'h0, bus_ack}, 32'h1);
    endtask

    task automatic bus_wr(input logic [3:0] a, input logic [31:0] wd);
        bus_req = 1'b1; bus_we = 1'b1; bus_addr = a; bus_wdata = wd;
        @(negedge clk);
        bus_req = 1'b0; bus_we = 1'b0;
        check("ack_wr", {31'h0, bus_ack}, 32'h1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    typedef struct {
        logic        we;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vt [12];

    initial begin
        logic [31:0] d;

        vt[0]  = '{1'b0, 4'h0, 32'h0,        32'h0};
        vt[1]  = '{1'b0, 4'h4, 32'h0,        32'h0};
        vt[2]  = '{1'b0, 4'hC, 32'h0,        32'h0};
        vt[3]  = '{1'b1, 4'hC, 32'hFFFFFFFF, 32'h0};
        vt[4]  = '{1'b0, 4'hC, 32'h0,        32'h0};
        vt[5]  = '{1'b1, 4'h0, 32'h000000FF, 32'h0};
        vt[6]  = '{1'b0, 4'h0, 32'h0,        32'h0};
        vt[7]  = '{1'b1, 4'h4, 32'h000000FF, 32'h0};
        vt[8]  = '{1'b0, 4'h5, 32'h0,        32'h0};
        vt[9]  = '{1'b1, 4'h8, 32'h000001A5, 32'h0};
        vt[10] = '{1'b0, 4'hB, 32'h0,        IRQEN_RB};
        vt[11] = '{1'b1, 4'h8, 32'h00000000, 32'h0};

        sw_in = 8'h00;
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(1);
        check("rst_irq", {31'h0, irq}, 32'h0);
        check("rst_ack", {31'h0, bus_ack}, 32'h0);
        check("rst_rdata", bus_rdata, 32'h0);

        for (int i = 0; i < 12; i++) begin
            if (vt[i].we) begin
                bus_wr(vt[i].addr, vt[i].wdata);
            end else begin
                bus_rd(vt[i].addr, d);
                check($sformatf("vec%0d", i), d, vt[i].exp);
            end
        end

        // latency: back-to-back DATA reads across the debounce window
        sw_in = 8'h81;
        for (int i = 0; i < 8; i++) begin
            bus_rd(4'h0, d);
            check($sformatf("data_lat%0d", i), d, (i >= 6) ? 32'h81 : 32'h0);
        end
        bus_rd(4'h4, d);
        check("edge_81", d, 32'h81);

        // short glitch on bit 3 is rejected
        sw_in = 8'h89;
        idle(2);
        sw_in = 8'h81;
        idle(10);
        bus_rd(4'h0, d);
        check("glitch_data", d, 32'h81);
        bus_rd(4'h4, d);
        check("glitch_edge", d, 32'h81);

        // W1C, then a clear landing on the same edge as a new bit-0 edge
        bus_wr(4'h4, 32'h01);
        bus_rd(4'h4, d);
        check("w1c_edge", d, 32'h80);
        sw_in = 8'h80;
        idle(5);
        bus_wr(4'h4, 32'h01);
        bus_rd(4'h4, d);
        check("set_wins", d, 32'h81);
        bus_rd(4'h0, d);
        check("data_80", d, 32'h80);

`ifdef SW_IRQ_EN
        bus_wr(4'h4, 32'hFF);
        bus_wr(4'h8, 32'h80);
        bus_rd(4'h8, d);
        check("irqen_rb", d, 32'h80);
        sw_in = 8'h00;
        idle(6);
        check("irq_pre", {31'h0, irq}, 32'h0);
        idle(1);
        check("irq_rise", {31'h0, irq}, 32'h1);
        bus_wr(4'h4, 32'h80);
        check("irq_hold", {31'h0, irq}, 32'h1);
        idle(1);
        check("irq_fall", {31'h0, irq}, 32'h0);
        sw_in = 8'h01;
        idle(10);
        check("irq_masked", {31'h0, irq}, 32'h0);
        bus_rd(4'h4, d);
        check("edge_masked", d, 32'h01);
`else
        bus_wr(4'h8, 32'hFF);
        bus_rd(4'h8, d);
        check("irqen_absent", d, 32'h0);
        bus_wr(4'h4, 32'hFF);
        sw_in = 8'h7F;
        idle(10);
        check("irq_tied", {31'h0, irq}, 32'h0);
        bus_rd(4'h4, d);
        check("edge_ff", d, 32'hFF);
`endif

        // reset during an access drops it
        bus_req = 1'b1; bus_we = 1'b1; bus_addr = 4'h8; bus_wdata = 32'hFF;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; bus_req = 1'b0; bus_we = 1'b0;
        check("rst_drop_ack", {31'h0, bus_ack}, 32'h0);
        bus_rd(4'h8, d);
        check("rst_drop_wr", d, 32'h0);
        bus_rd(4'h4, d);
        check("rst_edge", d, 32'h0);

        // randomized traffic checked against the model every cycle
        for (int cyc = 0; cyc < 2000; cyc++) begin
            rst = (cyc == 1000);
            if ($urandom_range(0, 5) == 0) sw_in = sw_in ^ 8'($urandom_range(1, 255));
            bus_req   = ($urandom_range(0, 1) == 1);
            bus_we    = ($urandom_range(0, 2) == 0);
            bus_addr  = 4'($urandom_range(0, 15));
            bus_wdata = $urandom;
            @(negedge clk);
        end
        rst = 1'b0;
        bus_req = 1'b0;
        bus_we = 1'b0;
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
